// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-system definitions: arbiter FSM states, port ids, counter
// widths and the round-robin grant helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    localparam int CNT_W = 16;  // completion counter width
    localparam int LAT_W = 4;   // holds ACCESS_LAT-1 for ACCESS_LAT up to 15

    // Pick the port to serve: a lone requester wins outright; on a conflict
    // the port that was not served last wins.
    function automatic port_id_e rr_pick(input logic i_valid, input logic d_valid,
                                         input port_id_e last);
        if (i_valid && d_valid)
            return (last == PORT_D) ? PORT_I : PORT_D;
        else if (d_valid)
            return PORT_D;
        else
            return PORT_I;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts completed accesses, sticks at all-ones.
module sat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request unless already at the ceiling.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported
// memory. One access in flight at a time: accept in IDLE, hold the memory
// bus for ACCESS_LAT cycles in BUSY, return the result in RESP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ACCESS_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch port
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    // data port
    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    // memory side
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    // statistics
    output logic [15:0]           i_count,
    output logic [15:0]           d_count
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ACCESS_LAT - 1);

    arb_state_e            state, state_next;
    port_id_e              grant;
    port_id_e              port_q;      // port being served; also round-robin history
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [LAT_W-1:0]      lat_q;
    logic [DATA_WIDTH-1:0] i_data_q;
    logic [DATA_WIDTH-1:0] d_data_q;
    logic                  handshake;
    logic                  sample;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state, handshake, write strobe and response pulses.
    always_comb begin
        state_next   = state;
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        mem_write_en = 1'b0;
        handshake    = 1'b0;
        sample       = 1'b0;
        grant        = rr_pick(i_req_valid, d_req_valid, port_q);
        unique case (state)
            IDLE: begin
                // Ready is withheld during reset so nothing is ever accepted
                // by a cycle whose state update is being discarded.
                if (!rst && (i_req_valid || d_req_valid)) begin
                    i_req_ready = (grant == PORT_I);
                    d_req_ready = (grant == PORT_D);
                    handshake   = 1'b1;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                // The counter only equals its load value in the first BUSY cycle.
                mem_write_en = we_q && (lat_q == LAT_INIT);
                if (lat_q == '0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // A reset landing on the response cycle cancels the pulse.
                i_resp_valid = !rst && (port_q == PORT_I);
                d_resp_valid = !rst && (port_q == PORT_D);
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, latency countdown and per-port response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q   <= PORT_I;   // so D wins the first conflict
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            if (handshake) begin
                port_q  <= grant;
                we_q    <= (grant == PORT_D) && d_req_we;   // fetches never write
                addr_q  <= (grant == PORT_D) ? d_req_addr : i_req_addr;
                wdata_q <= (grant == PORT_D) ? d_req_wdata : '0;
                lat_q   <= LAT_INIT;
            end else if ((state == BUSY) && (lat_q != '0)) begin
                lat_q <= lat_q - 1'b1;
            end
            if (sample) begin
                if (port_q == PORT_I)
                    i_data_q <= mem_read_data;
                else
                    d_data_q <= we_q ? wdata_q : mem_read_data;
            end
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign i_resp_data    = i_data_q;
    assign d_resp_data    = d_data_q;

    sat_counter #(.WIDTH(CNT_W)) u_i_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_resp_valid),
        .count (i_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_d_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_resp_valid),
        .count (d_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed spec vectors, a transaction table,
// hand-written corner sequences and a randomized run against a
// transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int LAT = 2;

    logic          clk, rst;
    logic          i_req_valid, i_req_ready, i_resp_valid;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_resp_data;
    logic          d_req_valid, d_req_we, d_req_ready, d_resp_valid;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata, d_resp_data;
    logic          mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic [15:0]   i_count, d_count;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .i_count(i_count), .d_count(d_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index since the last reset release
    int cyc;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // memory model: untouched words return a fixed address hash; the
    // override lets directed vectors present a chosen read value
    logic [DW-1:0] tb_mem [256];
    logic [255:0]  tb_wr = '0;
    logic          ovr_en;
    logic [DW-1:0] ovr_data;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'h33};
    endfunction

    always @(posedge clk) begin
        if (mem_write_en) begin
            tb_mem[mem_address] <= mem_write_data;
            tb_wr[mem_address]  <= 1'b1;
        end
    end

    assign mem_read_data = ovr_en ? ovr_data :
                           (tb_wr[mem_address] ? tb_mem[mem_address] : init_word(mem_address));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          port_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mdata;
        logic [DW-1:0] exp_data;
        int            exp_wr;
    } vec_t;

    // Issue one request on one port, hold it until accepted, then follow it
    // to its response. Starts and ends just after a rising edge.
    task automatic run_txn(input vec_t t, output int lat, output int wr_cnt,
                           output logic [AW-1:0] wr_addr, output logic other_resp,
                           output logic [DW-1:0] rdata);
        int hs;
        hs = -1; lat = -1; wr_cnt = 0; wr_addr = '0; other_resp = 1'b0; rdata = '0;
        ovr_data = t.mdata;
        d_req_we = t.we;
        if (t.port_d) begin
            d_req_valid = 1'b1; d_req_addr = t.addr; d_req_wdata = t.wdata;
        end else begin
            i_req_valid = 1'b1; i_req_addr = t.addr;
        end
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (hs < 0) begin
                if (t.port_d ? d_req_ready : i_req_ready) hs = k;
            end else begin
                if (mem_write_en) begin wr_cnt++; wr_addr = mem_address; end
                if (t.port_d ? i_resp_valid : d_resp_valid) other_resp = 1'b1;
                if (t.port_d ? d_resp_valid : i_resp_valid) begin
                    lat = k - hs;
                    rdata = t.port_d ? d_resp_data : i_resp_data;
                end
            end
            tick();
            if (hs >= 0) begin i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0; end
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
    endtask

    vec_t          vecs [6];
    vec_t          v;
    int            lat, wrc;
    logic [AW-1:0] wra;
    logic          oth;
    logic [DW-1:0] rd;

    // reference model state for the randomized run
    logic [DW-1:0] ref_mem [256];
    int            free_at, resp_at, wr_at, exp_ic, exp_dc;
    logic          last_d, m_port_d, m_we, g_d, hs_i, hs_d, e_ir, e_dr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_wdata, e_idata, e_ddata;
    logic [3:0]    order;
    int            ng, nr;

    initial begin
        rst = 1'b1; ovr_en = 1'b1; ovr_data = '0;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;

        // ---- reset state, then D load handshake in cycle 5 ----
        do_reset();
        @(negedge clk);
        chk("rst_ready", {i_req_ready, d_req_ready}, 2'b00);
        chk("rst_resp_valid", {i_resp_valid, d_resp_valid}, 2'b00);
        chk("rst_mem_we", mem_write_en, 1'b0);
        chk("rst_mem_bus", {mem_address, mem_write_data}, '0);
        chk("rst_resp_data", {i_resp_data, d_resp_data}, '0);
        chk("rst_counts", {i_count, d_count}, '0);
        while (cyc != 5) tick();
        ovr_data = 32'hDEADBEEF;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h10;
        @(negedge clk);
        chk("c5_d_ready", {i_req_ready, d_req_ready}, 2'b01);
        tick();
        d_req_valid = 1'b0;
        @(negedge clk);
        chk("c6_bus", {mem_write_en, mem_address, d_resp_valid}, {1'b0, 8'h10, 1'b0});
        tick();
        @(negedge clk);
        chk("c7_no_resp", d_resp_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("c8_resp", {i_resp_valid, d_resp_valid, d_resp_data}, {1'b0, 1'b1, 32'hDEADBEEF});
        tick();
        @(negedge clk);
        chk("c9_hold", {d_resp_valid, d_resp_data, d_count}, {1'b0, 32'hDEADBEEF, 16'd1});
        tick();

        // ---- transaction table ----
        vecs[0] = '{1'b1, 1'b1, 8'h20, 32'h12345678, 32'h55555555, 32'h12345678, 1};
        vecs[1] = '{1'b0, 1'b0, 8'h30, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0};
        vecs[2] = '{1'b0, 1'b1, 8'h31, 32'hFFFFFFFF, 32'h0BADF00D, 32'h0BADF00D, 0};
        vecs[3] = '{1'b1, 1'b0, 8'h7F, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 32'h0,        32'hAAAAAAAA, 32'h0,        1};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 0};
        for (int r = 0; r < 6; r++) begin
            run_txn(vecs[r], lat, wrc, wra, oth, rd);
            chk($sformatf("vec%0d_latency", r), lat, LAT + 1);
            chk($sformatf("vec%0d_data", r), rd, vecs[r].exp_data);
            chk($sformatf("vec%0d_wr_cnt", r), wrc, vecs[r].exp_wr);
            if (vecs[r].exp_wr != 0) chk($sformatf("vec%0d_wr_addr", r), wra, vecs[r].addr);
            chk($sformatf("vec%0d_other_resp", r), oth, 1'b0);
        end
        @(negedge clk);
        chk("tbl_hold", {i_resp_data, d_resp_data}, {32'hA5A5A5A5, 32'h0});
        tick();

        // ---- request arriving while busy waits, then is withdrawn ----
        ovr_data = 32'h01020304;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h50;
        @(negedge clk);
        chk("busy_d_hs", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 8'h51;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("busy_i_wait%0d", k), i_req_ready, 1'b0);
            tick();
        end
        i_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drop_quiet%0d", k), {i_req_ready, i_resp_valid, mem_write_en}, 3'b000);
            tick();
        end
        @(negedge clk);
        chk("drop_counts", {i_count, d_count, d_resp_data}, {16'd3, 16'd5, 32'h01020304});
        tick();

        // ---- reset in the second BUSY cycle of a store ----
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 8'h40; d_req_wdata = 32'hA1B2C3D4;
        @(negedge clk);
        chk("abort_hs", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0; d_req_we = 1'b0;
        @(negedge clk);
        chk("abort_first_busy_we", {mem_write_en, mem_address}, {1'b1, 8'h40});
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_cycle", d_resp_valid, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", k), {d_resp_valid, mem_write_en, d_req_ready}, 3'b000);
            tick();
        end
        @(negedge clk);
        chk("abort_d_count", d_count, 16'd0);
        tick();
        v = '{1'b1, 1'b0, 8'h41, 32'h0, 32'h13579BDF, 32'h13579BDF, 0};
        run_txn(v, lat, wrc, wra, oth, rd);
        chk("post_abort_latency", lat, LAT + 1);
        chk("post_abort_data", rd, 32'h13579BDF);
        @(negedge clk);
        chk("post_abort_d_count", d_count, 16'd1);
        tick();

        // ---- saturation of the data counter ----
        force dut.u_d_count.count = 16'hFFFE;
        tick();
        release dut.u_d_count.count;
        @(negedge clk);
        chk("sat_preload", d_count, 16'hFFFE);
        tick();
        for (int k = 0; k < 3; k++) begin
            v = '{1'b1, 1'b0, 8'h42, 32'h0, 32'h0000BEEF, 32'h0000BEEF, 0};
            run_txn(v, lat, wrc, wra, oth, rd);
            @(negedge clk);
            chk($sformatf("sat_load%0d", k), d_count, 16'hFFFF);
            tick();
        end
        tick(); tick();
        @(negedge clk);
        chk("sat_hold", d_count, 16'hFFFF);
        tick();

        // ---- both ports valid continuously from reset ----
        i_req_valid = 1'b1; i_req_addr = 8'h60;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 8'h61;
        do_reset();
        ng = 0; nr = 0; order = '0;
        for (int k = 0; k < 40 && nr < 4; k++) begin
            @(negedge clk);
            if (i_req_ready || d_req_ready) begin
                chk("rr_onehot", {i_req_ready, d_req_ready} == 2'b11, 1'b0);
                if (ng < 4) order[ng] = d_req_ready;
                ng++;
            end
            if (i_resp_valid || d_resp_valid) nr++;
            tick();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        chk("rr_responses", nr, 4);
        chk("rr_order_DIDI", order, 4'b0101);
        chk("rr_counts", {i_count, d_count}, {16'd2, 16'd2});
        tick();

        // ---- randomized run against the transaction model ----
        ovr_en = 1'b0;
        do_reset();
        for (int a = 0; a < 256; a++) ref_mem[a] = tb_wr[a] ? tb_mem[a] : init_word(8'(a));
        free_at = 0; resp_at = -1; wr_at = -1; exp_ic = 0; exp_dc = 0;
        last_d = 1'b0; m_port_d = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0; m_wdata = '0;
        e_idata = '0; e_ddata = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!i_req_valid && ($urandom_range(0, 2) == 0)) begin
                i_req_valid = 1'b1;
                i_req_addr  = 8'h80 | 8'($urandom_range(0, 127));
            end
            if (!d_req_valid && ($urandom_range(0, 2) == 0)) begin
                d_req_valid = 1'b1;
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_addr  = 8'h80 | 8'($urandom_range(0, 127));
                d_req_wdata = $urandom;
            end
            @(negedge clk);
            hs_i = 1'b0; hs_d = 1'b0; e_ir = 1'b0; e_dr = 1'b0; g_d = 1'b0;
            if (c >= free_at && (i_req_valid || d_req_valid)) begin
                g_d  = d_req_valid && (!i_req_valid || !last_d);
                e_dr = g_d;
                e_ir = !g_d;
            end
            if (c == resp_at) begin
                if (m_port_d) e_ddata = m_data; else e_idata = m_data;
            end
            chk("rnd_ready", {i_req_ready, d_req_ready}, {e_ir, e_dr});
            chk("rnd_resp_valid", {i_resp_valid, d_resp_valid},
                {(c == resp_at) && !m_port_d, (c == resp_at) && m_port_d});
            chk("rnd_resp_data", {i_resp_data, d_resp_data}, {e_idata, e_ddata});
            chk("rnd_mem_we", mem_write_en, c == wr_at);
            if (c == wr_at) chk("rnd_mem_wr", {mem_address, mem_write_data}, {m_addr, m_wdata});
            chk("rnd_counts", {i_count, d_count}, {16'(exp_ic), 16'(exp_dc)});
            if (c == resp_at) begin
                if (m_port_d) exp_dc++; else exp_ic++;
            end
            if (e_ir || e_dr) begin
                m_port_d = g_d;
                m_we     = g_d && d_req_we;
                m_addr   = g_d ? d_req_addr : i_req_addr;
                m_wdata  = d_req_wdata;
                m_data   = m_we ? d_req_wdata : ref_mem[m_addr];
                if (m_we) ref_mem[m_addr] = d_req_wdata;
                resp_at  = c + LAT + 1;
                wr_at    = m_we ? c + 1 : -1;
                free_at  = c + LAT + 2;
                last_d   = g_d;
                hs_d     = g_d;
                hs_i     = !g_d;
            end
            tick();
            if (hs_i) i_req_valid = 1'b0;
            if (hs_d) d_req_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
